// File: rtl/rep_retire_pkg.sv
// Shared definitions for REP string retirement: opsize codes,
// FSM states and the per-iteration pointer step.
package rep_retire_pkg;

    typedef enum logic [1:0] {
        OP_BYTE  = 2'd0,
        OP_WORD  = 2'd1,
        OP_DWORD = 2'd2,
        OP_RSVD  = 2'd3
    } opsize_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    // Small signed step; callers sign-extend to their datapath width.
    function automatic logic signed [3:0] step_delta(
        input logic [1:0] opsize,
        input logic       dflag
    );
        logic signed [3:0] mag;
        case (opsize)
            OP_BYTE:  mag = 4'sd1;
            OP_WORD:  mag = 4'sd2;
            OP_DWORD: mag = 4'sd4;
            default:  mag = 4'sd0;
        endcase
        return dflag ? -mag : mag;
    endfunction

endpackage

// File: rtl/rep_ptr_step.sv
// Pointer register with delta adder; the adder base is either the
// fresh start value (load) or the held register.
module rep_ptr_step #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] init,
    input  logic [W-1:0] delta,
    output logic [W-1:0] q,
    output logic [W-1:0] sum
);

    assign sum = (load ? init : q) + delta;

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= sum;
        end
    end

endmodule

// File: rtl/rep_retire.sv
// WB-side REP iteration tracker: counts retiring iterations, steps
// ESI/EDI, gates memory commits and writes final regs once.
module rep_retire
    import rep_retire_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         valid,
    input  logic         stall,
    input  logic         is_rep,
    input  logic [1:0]   opsize,
    input  logic         dflag,
    input  logic [W-1:0] creg_init,
    input  logic [W-1:0] esi_init,
    input  logic [W-1:0] edi_init,
    output logic         mem_commit,
    output logic [W-1:0] ecx_out,
    output logic [W-1:0] esi_out,
    output logic [W-1:0] edi_out,
    output logic         ld_rep_regs,
    output logic         rep_done,
    output logic         rep_busy,
    output logic         rep_err
);

    state_e       state;
    logic [W-1:0] remaining;
    logic [W-1:0] delta;
    logic [W-1:0] esi_r, edi_r;
    logic [W-1:0] esi_sum, edi_sum;
    logic         accept;
    logic         idle;
    logic         cnt_zero;
    logic         cnt_one;
    logic         ptr_en;

    assign accept   = valid & ~stall;
    assign idle     = (state == S_IDLE);
    assign cnt_zero = (creg_init == '0);
    assign cnt_one  = (creg_init == W'(1));
    assign delta    = W'(step_delta(opsize, dflag));
    assign rep_busy = (state == S_ACTIVE);

    // Pointers only need holding across a multi-iteration instruction.
    assign ptr_en = accept & is_rep
                  & (idle ? (~cnt_zero & ~cnt_one) : 1'b1);

    assign mem_commit = accept
                      & (idle ? (~is_rep | ~cnt_zero) : is_rep);

    rep_ptr_step #(.W(W)) u_esi (
        .clk   (clk),
        .clr   (clr),
        .en    (ptr_en),
        .load  (idle),
        .init  (esi_init),
        .delta (delta),
        .q     (esi_r),
        .sum   (esi_sum)
    );

    rep_ptr_step #(.W(W)) u_edi (
        .clk   (clk),
        .clr   (clr),
        .en    (ptr_en),
        .load  (idle),
        .init  (edi_init),
        .delta (delta),
        .q     (edi_r),
        .sum   (edi_sum)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_IDLE;
            remaining   <= '0;
            ecx_out     <= '0;
            esi_out     <= '0;
            edi_out     <= '0;
            ld_rep_regs <= 1'b0;
            rep_done    <= 1'b0;
            rep_err     <= 1'b0;
        end else begin
            ld_rep_regs <= 1'b0;
            rep_done    <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (is_rep) begin
                            if (cnt_zero) begin
                                ld_rep_regs <= 1'b1;
                                rep_done    <= 1'b1;
                                ecx_out     <= '0;
                                esi_out     <= esi_init;
                                edi_out     <= edi_init;
                            end else if (cnt_one) begin
                                ld_rep_regs <= 1'b1;
                                rep_done    <= 1'b1;
                                ecx_out     <= '0;
                                esi_out     <= esi_sum;
                                edi_out     <= edi_sum;
                            end else begin
                                remaining <= creg_init - W'(1);
                                state     <= S_ACTIVE;
                            end
                        end
                    end
                    S_ACTIVE: begin
                        if (is_rep) begin
                            remaining <= remaining - W'(1);
                            if (remaining == W'(1)) begin
                                ld_rep_regs <= 1'b1;
                                rep_done    <= 1'b1;
                                ecx_out     <= '0;
                                esi_out     <= esi_sum;
                                edi_out     <= edi_sum;
                                state       <= S_IDLE;
                            end
                        end else begin
                            rep_err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rep_retire.sv
// Directed bench for rep_retire: hand-computed vectors covering the
// normal, zero/one-count, stall, reset-abort, error and wrap cases.
module tb_rep_retire;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         valid;
    logic         stall;
    logic         is_rep;
    logic [1:0]   opsize;
    logic         dflag;
    logic [W-1:0] creg_init;
    logic [W-1:0] esi_init;
    logic [W-1:0] edi_init;
    logic         mem_commit;
    logic [W-1:0] ecx_out;
    logic [W-1:0] esi_out;
    logic [W-1:0] edi_out;
    logic         ld_rep_regs;
    logic         rep_done;
    logic         rep_busy;
    logic         rep_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rep_retire #(.W(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .valid       (valid),
        .stall       (stall),
        .is_rep      (is_rep),
        .opsize      (opsize),
        .dflag       (dflag),
        .creg_init   (creg_init),
        .esi_init    (esi_init),
        .edi_init    (edi_init),
        .mem_commit  (mem_commit),
        .ecx_out     (ecx_out),
        .esi_out     (esi_out),
        .edi_out     (edi_out),
        .ld_rep_regs (ld_rep_regs),
        .rep_done    (rep_done),
        .rep_busy    (rep_busy),
        .rep_err     (rep_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a uop just after the falling edge.
    task automatic drive(input logic v, input logic s, input logic r,
                         input logic [1:0] os, input logic df,
                         input logic [31:0] c, input logic [31:0] si,
                         input logic [31:0] di);
        @(negedge clk);
        valid     = v;
        stall     = s;
        is_rep    = r;
        opsize    = os;
        dflag     = df;
        creg_init = c;
        esi_init  = si;
        edi_init  = di;
    endtask

    // Check the combinational commit, then advance past the rising edge.
    task automatic cyc(input string tag, input logic exp_mc);
        #1 check({tag, "_mc"}, mem_commit, exp_mc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
        cyc("idle", 1'b0);
    endtask

    initial begin
        clr = 1'b1;
        drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("rst_ecx",  ecx_out, 0);
        check("rst_esi",  esi_out, 0);
        check("rst_edi",  edi_out, 0);
        check("rst_ld",   ld_rep_regs, 0);
        check("rst_done", rep_done, 0);
        check("rst_busy", rep_busy, 0);
        check("rst_err",  rep_err, 0);

        // ECX=3 dword forward
        drive(1, 0, 1, 2'd2, 0, 3, 32'h100, 32'h200);
        cyc("t1_i1", 1);
        check("t1_busy1", rep_busy, 1);
        check("t1_ld1", ld_rep_regs, 0);
        drive(1, 0, 1, 2'd2, 0, 3, 32'h100, 32'h200);
        cyc("t1_i2", 1);
        check("t1_ld2", ld_rep_regs, 0);
        drive(1, 0, 1, 2'd2, 0, 3, 32'h100, 32'h200);
        cyc("t1_i3", 1);
        check("t1_ld",   ld_rep_regs, 1);
        check("t1_done", rep_done, 1);
        check("t1_ecx",  ecx_out, 0);
        check("t1_esi",  esi_out, 32'h10C);
        check("t1_edi",  edi_out, 32'h20C);
        check("t1_busy", rep_busy, 0);
        idle_cyc();
        check("t1_ld_off", ld_rep_regs, 0);
        check("t1_hold",   esi_out, 32'h10C);

        // ECX=0 byte: nothing moves, still one commit pulse
        drive(1, 0, 1, 2'd0, 0, 0, 32'h55, 32'h66);
        cyc("t2", 0);
        check("t2_ld",   ld_rep_regs, 1);
        check("t2_done", rep_done, 1);
        check("t2_ecx",  ecx_out, 0);
        check("t2_esi",  esi_out, 32'h55);
        check("t2_edi",  edi_out, 32'h66);
        check("t2_busy", rep_busy, 0);

        // ECX=2 word backward with a two-cycle stall
        drive(1, 0, 1, 2'd1, 1, 2, 32'h1000, 32'h2000);
        cyc("t3_i1", 1);
        check("t3_busy", rep_busy, 1);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 2'd1, 1, 2, 32'h1000, 32'h2000);
            cyc("t3_stall", 0);
            check("t3_stall_ld",   ld_rep_regs, 0);
            check("t3_stall_busy", rep_busy, 1);
        end
        drive(1, 0, 1, 2'd1, 1, 2, 32'h1000, 32'h2000);
        cyc("t3_i2", 1);
        check("t3_ld",  ld_rep_regs, 1);
        check("t3_esi", esi_out, 32'h0FFC);
        check("t3_edi", edi_out, 32'h1FFC);
        check("t3_idle", rep_busy, 0);

        // ECX=4 aborted by clr after two iterations
        drive(1, 0, 1, 2'd2, 0, 4, 32'h300, 32'h400);
        cyc("t4_i1", 1);
        drive(1, 0, 1, 2'd2, 0, 4, 32'h300, 32'h400);
        cyc("t4_i2", 1);
        check("t4_busy", rep_busy, 1);
        check("t4_ld",   ld_rep_regs, 0);
        drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
        clr = 1'b1;
        cyc("t4_clr", 0);
        clr = 1'b0;
        check("t4_busy_clr", rep_busy, 0);
        check("t4_ld_clr",   ld_rep_regs, 0);
        check("t4_ecx",      ecx_out, 0);
        check("t4_esi",      esi_out, 0);
        check("t4_edi",      edi_out, 0);

        // Non-REP uop while ACTIVE flags a sticky error
        drive(1, 0, 0, 2'd0, 0, 0, 0, 0);
        cyc("t5_idle_nonrep", 1);
        check("t5_err0", rep_err, 0);
        drive(1, 0, 1, 2'd2, 0, 3, 32'h10, 32'h20);
        cyc("t5_i1", 1);
        drive(1, 0, 0, 2'd2, 0, 3, 32'h10, 32'h20);
        cyc("t5_bad", 0);
        check("t5_err",  rep_err, 1);
        check("t5_busy", rep_busy, 1);
        idle_cyc();
        check("t5_sticky", rep_err, 1);
        drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
        clr = 1'b1;
        cyc("t5_clr", 0);
        clr = 1'b0;
        check("t5_err_clr", rep_err, 0);

        // ECX=1 byte: pointer wraps, single pulse, no ACTIVE
        drive(1, 0, 1, 2'd0, 0, 1, 32'hFFFF_FFFF, 32'h10);
        #1 check("t6_busy_pre", rep_busy, 0);
        cyc("t6", 1);
        check("t6_ld",   ld_rep_regs, 1);
        check("t6_done", rep_done, 1);
        check("t6_esi",  esi_out, 32'h0);
        check("t6_edi",  edi_out, 32'h11);
        check("t6_ecx",  ecx_out, 0);
        check("t6_busy", rep_busy, 0);
        idle_cyc();
        check("t6_single", ld_rep_regs, 0);

        // Reserved opsize steps by zero
        drive(1, 0, 1, 2'd3, 0, 1, 32'h77, 32'h88);
        cyc("t7", 1);
        check("t7_esi", esi_out, 32'h77);
        check("t7_edi", edi_out, 32'h88);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rep_retire.md
Name: rep_retire

Overview:
- Writeback-side consumer of REP string iterations issued by the RrAg repeat mechanism.
- Counts the iterations that retire at WB, tracks the architectural ECX/ESI/EDI of the in-flight REP instruction, and gates each iteration's memory commit.
- Commits the final ECX/ESI/EDI to the register file exactly once, when the last iteration retires, then returns to idle.

Parameters:
- W, 32, width of the count and pointer datapath.

Ports:
- clk  in  1  clock
- clr  in  1  synchronous active-high reset
- valid  in  1  a uop is present at WB this cycle
- stall  in  1  WB stalled; the uop is not accepted this cycle
- is_rep  in  1  uop is an iteration of a REP string instruction
- opsize  in  2  0=byte, 1=word, 2=dword, 3=reserved (treat as delta 0)
- dflag  in  1  direction flag (1 = decrement pointers)
- creg_init  in  W  ECX value at instruction start (carried down the pipe)
- esi_init  in  W  ESI value at instruction start
- edi_init  in  W  EDI value at instruction start
- mem_commit  out  1  allow this iteration's memory write
- ecx_out, esi_out, edi_out  out  W  final architectural values
- ld_rep_regs  out  1  1-cycle pulse: write ecx/esi/edi_out to the register file
- rep_done  out  1  1-cycle pulse, coincident with ld_rep_regs
- rep_busy  out  1  FSM is in ACTIVE
- rep_err  out  1  sticky protocol error

Behaviour:
- accept = valid & ~stall. Nothing changes state on a cycle without accept.
- delta = +1/+2/+4 for opsize 0/1/2 when dflag=0; the negation when dflag=1; 0 for opsize 3. All arithmetic is mod 2^W with no carry-out.
- Registers: remaining, esi_r, edi_r, state, plus registered outputs.
- Reset (clr, synchronous, highest priority over all other events):
  - state=IDLE
  - remaining=esi_r=edi_r=0
  - ecx_out=esi_out=edi_out=0
  - ld_rep_regs=rep_done=rep_err=0
- FSM states: IDLE, ACTIVE.
- IDLE, accept & is_rep & creg_init==0:
  - zero-iteration REP; mem_commit=0
  - next cycle: ld_rep_regs=1, rep_done=1, ecx_out=0, esi_out=esi_init, edi_out=edi_init
  - stay IDLE
- IDLE, accept & is_rep & creg_init==1:
  - mem_commit=1
  - next cycle: ld_rep_regs=1, ecx_out=0, esi_out=esi_init+delta, edi_out=edi_init+delta
  - stay IDLE
- IDLE, accept & is_rep & creg_init>1:
  - mem_commit=1
  - remaining<=creg_init-1, esi_r<=esi_init+delta, edi_r<=edi_init+delta
  - go to ACTIVE
- ACTIVE, accept & is_rep:
  - mem_commit=1
  - remaining<=remaining-1; esi_r, edi_r step by delta
  - if remaining==1: next cycle ld_rep_regs=1, rep_done=1, outputs carry the final values (ecx 0); go to IDLE
- ACTIVE, accept & ~is_rep:
  - rep_err<=1 (sticky until clr)
  - mem_commit=0; the uop is dropped from REP tracking; state unchanged
- Any state, accept & ~is_rep while IDLE: mem_commit=1, no other effect.
- mem_commit is combinational: 0 whenever accept=0.
- rep_busy = (state==ACTIVE).
- ld_rep_regs and rep_done are registered and high for exactly one cycle. ecx/esi/edi_out hold their last committed values otherwise.
- opsize and dflag are sampled per iteration. A change mid-instruction is not flagged; the pointer step uses the current iteration's values.
- Stall mid-REP: registers hold and no pulse is issued; the iteration completes on the later accept.
- clr asserted while ACTIVE: in-flight REP abandoned, no commit, IDLE on the next cycle.
- Back-to-back: a new REP starting in IDLE on the cycle right after a commit pulse is legal. A commit pulse and a new REP's first accept may overlap.

Decomposition:
- Shared package: opsize encodings, the FSM state enum, and a step-delta function (opsize, dflag) -> W-bit delta, reused by the RrAg repeat logic.
- One natural sub-module, rep_ptr_step: W-bit register + delta adder with hold/load, instantiated for ESI and EDI.
- Counter and FSM stay in the top level.

Test Plan:
- ECX=3, ESI=0x100, EDI=0x200, opsize=2, dflag=0, three accepts -> mem_commit 1,1,1; one cycle after the third: ld_rep_regs=1, ecx_out=0, esi_out=0x10C, edi_out=0x20C, rep_busy returns 0.
- ECX=0, byte op -> mem_commit=0; next cycle ld_rep_regs=1, esi_out=ESI, edi_out=EDI unchanged; rep_busy never 1.
- ECX=2, opsize=1, dflag=1, ESI=0x1000, stall high for 2 cycles between iterations -> no early pulse; final esi_out=0x0FFC.
- ECX=4, ACTIVE after 2 iterations, clr asserted -> next cycle IDLE, ld_rep_regs never pulses, all outputs 0.
- ACTIVE with a non-REP uop accepted -> rep_err=1 and stays 1; mem_commit=0 for that uop.
- ECX=1, ESI=0xFFFFFFFF, byte, dflag=0 -> esi_out=0x00000000 (wrap), single pulse, no ACTIVE entry.
